// File: rtl/mem_latency_responder.sv
// Memory-side line responder: one request at a time, served from a line array after LATENCY cycles.
// Optional MEM_RANGE_CHECK_EN adds err_o and blocks out-of-range accesses instead of aliasing them.
module mem_latency_responder #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
`ifdef MEM_RANGE_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [7:0]  CNT_LAST = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                write_q;
  logic                accept, access;
  logic [LINE_W-1:0]   memory [DEPTH];

  logic unused_addr;
  assign unused_addr = ^{addr_i[4:0], addr_i[ADDR_W-1:IDX_W+5]};

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH) << 5;
  logic oor_q;
`endif

  // WAIT always lasts LATENCY cycles (cnt runs 0..LATENCY-1), so ack rises on edge E0+LATENCY even for LATENCY=1.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          access  = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_o   <= 1'b0;
      data_o  <= '0;
`ifdef MEM_RANGE_CHECK_EN
      err_o   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_o   <= access;
      if (accept || access) begin
        cnt_q <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
`ifdef MEM_RANGE_CHECK_EN
      err_o <= access && oor_q;
      if (access && !write_q) begin
        data_o <= oor_q ? '0 : memory[idx_q];
      end
`else
      if (access && !write_q) begin
        data_o <= memory[idx_q];
      end
`endif
    end
  end

  // Request latches and the array itself are not reset; a reset at the access edge blocks the commit.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= addr_i[IDX_W+4:5];
      wdata_q <= data_i;
      write_q <= write_i;
`ifdef MEM_RANGE_CHECK_EN
      oor_q   <= ({1'b0, addr_i} >= ADDR_LIMIT);
`endif
    end
`ifdef MEM_RANGE_CHECK_EN
    if (!rst_i && access && write_q && !oor_q) begin
      memory[idx_q] <= wdata_q;
    end
`else
    if (!rst_i && access && write_q) begin
      memory[idx_q] <= wdata_q;
    end
`endif
  end

endmodule

// File: tb/tb_mem_latency_responder.sv
// Directed bench for mem_latency_responder: a LATENCY=10 instance and a LATENCY=1 instance.
// Honours MEM_RANGE_CHECK_EN when the bundle is built with it.
module tb_mem_latency_responder;

  localparam logic [255:0] PAT_A    = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222_3333_4444_5555_6666_7777_0000;
  localparam logic [255:0] PAT_ECFA = {16{16'hECFA}};
  localparam logic [255:0] PAT_B    = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] PAT_C    = {8{32'h1234_5678}};
  localparam logic [255:0] PAT_D    = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] PAT_E    = {8{32'hA5A5_5A5A}};
  localparam logic [255:0] PAT_L1   = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

  logic         clk;
  logic         rst;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         en;
  logic         wr;
  logic         ack;
  logic [255:0] rdata;
  logic         busy;
  logic [31:0]  addr1;
  logic [255:0] wdata1;
  logic         en1;
  logic         wr1;
  logic         ack1;
  logic [255:0] rdata1;
  logic         busy1;
`ifdef MEM_RANGE_CHECK_EN
  logic         err;
  logic         err1;
`endif

  int checks;
  int errors;

  mem_latency_responder #(.LATENCY(10), .DEPTH(512), .LINE_W(256), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .enable_i(en), .write_i(wr),
    .ack_o(ack), .data_o(rdata), .busy_o(busy)
`ifdef MEM_RANGE_CHECK_EN
    , .err_o(err)
`endif
  );

  mem_latency_responder #(.LATENCY(1), .DEPTH(512), .LINE_W(256), .ADDR_W(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr1), .data_i(wdata1), .enable_i(en1), .write_i(wr1),
    .ack_o(ack1), .data_o(rdata1), .busy_o(busy1)
`ifdef MEM_RANGE_CHECK_EN
    , .err_o(err1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({ack1, busy1} !== 2'b00) begin errors++; $display("FAIL reset_l1_ack_busy: got %b expected 00", {ack1, busy1}); end
`ifdef MEM_RANGE_CHECK_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_latency();
    int ack_k, n_ack, busy_gaps;
    logic [255:0] got;
    ack_k = 0; n_ack = 0; busy_gaps = 0; got = '0;
    dut.memory[1] = PAT_A;
    addr = 32'h20; wr = 1'b0; en = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_e0: got %b expected 1", busy); end
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (ack === 1'b1) begin n_ack++; ack_k = k; got = rdata; en = 1'b0; end
      if (k <= 10 && busy !== 1'b1) busy_gaps++;
      if (k == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after: got %b expected 0", busy); end
        checks++; if (rdata !== PAT_A) begin errors++; $display("FAIL read_data_hold: got %h expected %h", rdata, PAT_A); end
      end
    end
    checks++; if (ack_k != 10) begin errors++; $display("FAIL read_ack_cycle: got %0d expected 10", ack_k); end
    checks++; if (n_ack != 1) begin errors++; $display("FAIL read_ack_count: got %0d expected 1", n_ack); end
    checks++; if (got !== PAT_A) begin errors++; $display("FAIL read_data: got %h expected %h", got, PAT_A); end
    checks++; if (busy_gaps != 0) begin errors++; $display("FAIL read_busy_gaps: got %0d expected 0", busy_gaps); end
  endtask

  task automatic test_write_then_read();
    int ack_k;
    logic [255:0] got;
    ack_k = 0; got = '0;
    dut.memory[32] = '0;
    addr = 32'h400; wdata = PAT_ECFA; wr = 1'b1; en = 1'b1;
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) begin
        checks++; if (dut.memory[32] !== '0) begin errors++; $display("FAIL write_early_commit: got %h expected 0", dut.memory[32]); end
      end
      if (k == 10) begin
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_ack: got %b expected 1", ack); end
        checks++; if (dut.memory[32] !== PAT_ECFA) begin errors++; $display("FAIL write_commit: got %h expected %h", dut.memory[32], PAT_ECFA); end
        checks++; if (rdata !== PAT_A) begin errors++; $display("FAIL write_data_o_unchanged: got %h expected %h", rdata, PAT_A); end
        en = 1'b0; wr = 1'b0;
      end
    end
    addr = 32'h41F; en = 1'b1;
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (ack === 1'b1) begin ack_k = k; got = rdata; en = 1'b0; end
    end
    checks++; if (ack_k != 10) begin errors++; $display("FAIL raw_ack_cycle: got %0d expected 10", ack_k); end
    checks++; if (got !== PAT_ECFA) begin errors++; $display("FAIL raw_data: got %h expected %h", got, PAT_ECFA); end
  endtask

  task automatic test_enable_held();
    int n_ack, first_k, second_k;
    n_ack = 0; first_k = 0; second_k = 0;
    addr = 32'h20; wr = 1'b0; en = 1'b1;
    tick();
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (ack === 1'b1) begin
        n_ack++;
        if (n_ack == 1) first_k = k; else second_k = k;
      end
      if (k == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_busy: got %b expected 0", busy); end
      end
      if (k == 12) en = 1'b0;
    end
    checks++; if (n_ack != 2) begin errors++; $display("FAIL held_ack_count: got %0d expected 2", n_ack); end
    checks++; if (first_k != 10) begin errors++; $display("FAIL held_first_ack: got %0d expected 10", first_k); end
    checks++; if (second_k != 22) begin errors++; $display("FAIL held_second_ack: got %0d expected 22", second_k); end
  endtask

  task automatic test_reset_mid();
    int n_ack;
    n_ack = 0;
    dut.memory[2] = PAT_B;
    addr = 32'h40; wdata = PAT_C; wr = 1'b1; en = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (ack === 1'b1) n_ack++;
    end
    rst = 1'b1; en = 1'b0; wr = 1'b0;
    tick();
    checks++; if ({ack, busy} !== 2'b00) begin errors++; $display("FAIL midrst_ack_busy: got %b expected 00", {ack, busy}); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL midrst_data: got %h expected 0", rdata); end
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (ack === 1'b1) n_ack++;
    end
    checks++; if (n_ack != 0) begin errors++; $display("FAIL midrst_no_ack: got %0d expected 0", n_ack); end
    checks++; if (dut.memory[2] !== PAT_B) begin errors++; $display("FAIL midrst_mem: got %h expected %h", dut.memory[2], PAT_B); end
  endtask

  task automatic test_latency1();
    int ack_k, n_ack;
    logic [255:0] got;
    ack_k = 0; n_ack = 0; got = '0;
    dut1.memory[0] = PAT_L1;
    addr1 = 32'h0; en1 = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (ack1 === 1'b1) begin n_ack++; ack_k = k; got = rdata1; en1 = 1'b0; end
      if (k == 2) begin
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL l1_busy_after: got %b expected 0", busy1); end
      end
    end
    checks++; if (ack_k != 1) begin errors++; $display("FAIL l1_ack_cycle: got %0d expected 1", ack_k); end
    checks++; if (n_ack != 1) begin errors++; $display("FAIL l1_ack_count: got %0d expected 1", n_ack); end
    checks++; if (got !== PAT_L1) begin errors++; $display("FAIL l1_data: got %h expected %h", got, PAT_L1); end
  endtask

  task automatic test_range();
    int ack_k;
    logic err_at_ack, err_other;
    ack_k = 0; err_at_ack = 1'b0; err_other = 1'b0;
    dut.memory[0] = PAT_E;
    addr = 32'h4000; wdata = PAT_D; wr = 1'b1; en = 1'b1;
    tick();
    for (int k = 1; k <= 11; k++) begin
      tick();
`ifdef MEM_RANGE_CHECK_EN
      if (ack === 1'b1) err_at_ack = err; else if (err !== 1'b0) err_other = 1'b1;
`endif
      if (ack === 1'b1) begin ack_k = k; en = 1'b0; wr = 1'b0; end
    end
    checks++; if (ack_k != 10) begin errors++; $display("FAIL range_ack_cycle: got %0d expected 10", ack_k); end
`ifdef MEM_RANGE_CHECK_EN
    checks++; if (err_at_ack !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", err_at_ack); end
    checks++; if (err_other !== 1'b0) begin errors++; $display("FAIL range_err_outside_ack: got %b expected 0", err_other); end
    checks++; if (dut.memory[0] !== PAT_E) begin errors++; $display("FAIL range_mem_kept: got %h expected %h", dut.memory[0], PAT_E); end
`else
    checks++; if (dut.memory[0] !== PAT_D) begin errors++; $display("FAIL range_alias_write: got %h expected %h", dut.memory[0], PAT_D); end
`endif
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; addr = '0; wdata = '0; en = 1'b0; wr = 1'b0;
    addr1 = '0; wdata1 = '0; en1 = 1'b0; wr1 = 1'b0;
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_enable_held();
    test_reset_mid();
    test_latency1();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
